// File: rtl/wb_pkg.sv
// ============================================================================
//  Module  : wb_pkg
//  Brief   : Shared types, constants and helpers for the write buffer.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

// Store-width codes shared with the cache; left alone if already defined.
`ifndef DATA_ADDR_MODE_B
`define DATA_ADDR_MODE_B  3'b000
`endif
`ifndef DATA_ADDR_MODE_H
`define DATA_ADDR_MODE_H  3'b001
`endif
`ifndef DATA_ADDR_MODE_W
`define DATA_ADDR_MODE_W  3'b010
`endif
`ifndef DATA_ADDR_MODE_BU
`define DATA_ADDR_MODE_BU 3'b100
`endif
`ifndef DATA_ADDR_MODE_HU
`define DATA_ADDR_MODE_HU 3'b101
`endif

package wb_pkg;

  localparam int NUM_LANES     = 4;
  localparam int WB_ADDR_WIDTH = 32;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-3:0] word_addr;
    logic [31:0]              wdata;
    logic [NUM_LANES-1:0]     be;
  } wb_entry_t;

  // Lanes enabled in new_be take new data; the rest keep the old bytes.
  function automatic logic [31:0] merge_lanes(input logic [31:0]          old_data,
                                              input logic [31:0]          new_data,
                                              input logic [NUM_LANES-1:0] new_be);
    logic [31:0] result;
    result = old_data;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (new_be[l]) result[l*8 +: 8] = new_data[l*8 +: 8];
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/write_buffer_if.sv
// ============================================================================
//  Module  : write_buffer_if
//  Brief   : Cache-side enqueue, memory-side drain and lookup bus.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface write_buffer_if
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  enq_valid;
  logic                  enq_ready;
  logic [ADDR_WIDTH-1:0] enq_addr;
  logic [2:0]            enq_addr_mode;
  logic [DATA_WIDTH-1:0] enq_data;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NUM_LANES-1:0]  mem_be;

  logic [ADDR_WIDTH-1:0] lookup_addr;
  logic                  lookup_hit;

  // Buffer side.
  modport slave (
    input  enq_valid, enq_addr, enq_addr_mode, enq_data,
    output enq_ready,
    output mem_req_valid, mem_addr, mem_wdata, mem_be,
    input  mem_req_ready,
    input  lookup_addr,
    output lookup_hit
  );

  // Cache / memory side.
  modport master (
    output enq_valid, enq_addr, enq_addr_mode, enq_data,
    input  enq_ready,
    input  mem_req_valid, mem_addr, mem_wdata, mem_be,
    output mem_req_ready,
    output lookup_addr,
    input  lookup_hit
  );

endinterface

`default_nettype wire

// File: rtl/write_buffer_store_lane_align.sv
// ============================================================================
//  Module  : store_lane_align
//  Brief   : Combinational store alignment: byte enables and lane-replicated data.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module store_lane_align
  import wb_pkg::*;
(
  input  logic [1:0]           addr_lsb,
  input  logic [2:0]           addr_mode,
  input  logic [31:0]          data,
  output logic [NUM_LANES-1:0] be,
  output logic [31:0]          lane_data
);

  // Signed/unsigned variants only differ on loads, so they share an arm.
  always_comb begin
    be        = 4'b1111;
    lane_data = data;
    case (addr_mode)
      `DATA_ADDR_MODE_B, `DATA_ADDR_MODE_BU: begin
        be        = 4'b0001 << addr_lsb;
        lane_data = {4{data[7:0]}};
      end
      `DATA_ADDR_MODE_H, `DATA_ADDR_MODE_HU: begin
        be        = addr_lsb[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{data[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        lane_data = data;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/write_buffer.sv
// ============================================================================
//  Module  : write_buffer
//  Brief   : In-order store buffer between write-through D-cache and memory.
//            Optional macro WRITE_BUFFER_MERGE_EN merges into the youngest entry.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module write_buffer
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  write_buffer_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam int              WA_W       = ADDR_WIDTH - 2;
  localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W+1)'(DEPTH);

  wb_entry_t            r_entries [DEPTH];
  logic [DEPTH-1:0]     r_valid;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [PTR_W:0]       r_count;

  logic [NUM_LANES-1:0] w_be;
  logic [DATA_WIDTH-1:0] w_lane_data;
  logic [WA_W-1:0]      w_enq_word;
  wb_entry_t            w_head;
  logic                 w_deq;
  logic                 w_enq;
  logic                 w_alloc;
  logic                 w_merge;
  logic                 w_full;
  logic                 w_hit;
  logic                 unused_lookup_lsb;

  store_lane_align u_align (
    .addr_lsb  (bus.enq_addr[1:0]),
    .addr_mode (bus.enq_addr_mode),
    .data      (bus.enq_data),
    .be        (w_be),
    .lane_data (w_lane_data)
  );

  assign w_enq_word = bus.enq_addr[ADDR_WIDTH-1:2];
  assign w_full     = (r_count == FULL_COUNT);
  assign w_head     = r_entries[r_head];
  assign w_deq      = (r_count != '0) && bus.mem_req_ready;

`ifdef WRITE_BUFFER_MERGE_EN
  logic [PTR_W-1:0] w_youngest;
  assign w_youngest = r_tail - 1'b1;
  // The head leaving this cycle cannot absorb a merge; it allocates instead.
  assign w_merge = (r_count != '0)
                && (r_entries[w_youngest].word_addr == w_enq_word)
                && !(w_deq && (w_youngest == r_head));
`else
  assign w_merge = 1'b0;
`endif

  assign bus.enq_ready = !w_full || w_merge;
  assign w_enq         = bus.enq_valid && bus.enq_ready;
  assign w_alloc       = w_enq && !w_merge;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_alloc) r_tail <= r_tail + 1'b1;
      if (w_deq)   r_head <= r_head + 1'b1;
      case ({w_alloc, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Alloc and dequeue never target the same slot in one cycle.
      if (w_deq)   r_valid[r_head] <= 1'b0;
      if (w_alloc) r_valid[r_tail] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_entries[r_tail] <= '{word_addr: w_enq_word, wdata: w_lane_data, be: w_be};
    end
`ifdef WRITE_BUFFER_MERGE_EN
    else if (w_merge) begin
      r_entries[w_youngest].be    <= r_entries[w_youngest].be | w_be;
      r_entries[w_youngest].wdata <= merge_lanes(r_entries[w_youngest].wdata, w_lane_data, w_be);
    end
`endif
  end

  // Registered entries only, so a same-cycle enqueue is not seen here.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_entries[i].word_addr == bus.lookup_addr[ADDR_WIDTH-1:2])) begin
        w_hit = 1'b1;
      end
    end
  end

  assign unused_lookup_lsb = ^bus.lookup_addr[1:0];

  assign bus.lookup_hit    = w_hit;
  assign bus.mem_req_valid = (r_count != '0);
  assign bus.mem_addr      = {w_head.word_addr, 2'b00};
  assign bus.mem_wdata     = w_head.wdata;
  assign bus.mem_be        = w_head.be;

  assign count = r_count;
  assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_write_buffer.sv
// ============================================================================
//  Module  : tb_write_buffer
//  Brief   : Scoreboard bench for write_buffer (directed store vectors).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_write_buffer;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] count;
  logic       empty;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  write_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  write_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .count (count),
    .empty (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drain monitor: pops one expectation per handshake, in order.
  always @(negedge clk) begin
    if (!rst && bus.mem_req_valid && bus.mem_req_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL drain_unexpected actual addr=%h be=%b data=%h required none",
                 bus.mem_addr, bus.mem_be, bus.mem_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.mem_addr !== e.addr || bus.mem_be !== e.be || bus.mem_wdata !== e.wdata) begin
          errors++;
          $display("FAIL drain_write actual addr=%h be=%b data=%h required addr=%h be=%b data=%h",
                   bus.mem_addr, bus.mem_be, bus.mem_wdata, e.addr, e.be, e.wdata);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic enq(input logic [31:0] addr, input logic [2:0] mode, input logic [31:0] data,
                     input bit push, input logic [31:0] ea, input logic [3:0] ebe,
                     input logic [31:0] ed);
    int n;
    exp_t e;
    n = 0;
    bus.enq_addr      = addr;
    bus.enq_addr_mode = mode;
    bus.enq_data      = data;
    bus.enq_valid     = 1'b1;
    #1;
    while (!bus.enq_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL enq_timeout actual enq_ready=0 required 1 addr=%h", addr);
      bus.enq_valid = 1'b0;
    end else begin
      if (push) begin
        e.addr = ea; e.be = ebe; e.wdata = ed;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.enq_valid = 1'b0;
    end
  endtask

  task automatic enq_w(input logic [31:0] addr, input logic [31:0] data);
    enq(addr, 3'b010, data, 1'b1, {addr[31:2], 2'b00}, 4'b1111, data);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    bus.mem_req_ready = 1'b1;
    while (!empty && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", 32'(empty), 32'd1);
    bus.mem_req_ready = 1'b0;
  endtask

  initial begin
    bus.enq_valid     = 1'b0;
    bus.enq_addr      = '0;
    bus.enq_addr_mode = 3'b010;
    bus.enq_data      = '0;
    bus.mem_req_ready = 1'b0;
    bus.lookup_addr   = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_enq_ready", 32'(bus.enq_ready), 32'd1);
    check("rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_lookup_hit", 32'(bus.lookup_hit), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);

    // Fill with memory stalled.
    for (int i = 0; i < 4; i++) enq_w(32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i));
    check("fill_count", 32'(count), 32'd4);
    check("fill_enq_ready", 32'(bus.enq_ready), 32'd0);
    check("fill_mem_valid", 32'(bus.mem_req_valid), 32'd1);
    check("fill_mem_addr", bus.mem_addr, 32'h100);
    check("fill_mem_be", 32'(bus.mem_be), 32'hF);

    // Ordered drain, one per cycle.
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_addr", bus.mem_addr, 32'h100 + 32'(4*i));
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_mem_valid", 32'(bus.mem_req_valid), 32'd0);
    bus.mem_req_ready = 1'b0;

    // Alignment.
    enq(32'h203, 3'b000, 32'h0000_00AB, 1'b1, 32'h200, 4'b1000, 32'hABAB_ABAB);
    check("sb_mem_addr", bus.mem_addr, 32'h200);
    check("sb_mem_be", 32'(bus.mem_be), 32'h8);
    check("sb_byte3", 32'(bus.mem_wdata[31:24]), 32'hAB);
    bus.mem_req_ready = 1'b1;
    enq_w(32'h2F0, 32'hCAFE_F00D);
    enq(32'h206, 3'b001, 32'hFFFF_1234, 1'b1, 32'h204, 4'b1100, 32'h1234_1234);
    enq(32'h209, 3'b101, 32'h0000_BEEF, 1'b1, 32'h208, 4'b0011, 32'hBEEF_BEEF);
    enq(32'h20E, 3'b011, 32'h1234_5678, 1'b1, 32'h20C, 4'b1111, 32'h1234_5678);
    wait_drain();

    // Lookup.
    enq_w(32'h300, 32'h0000_0033);
    bus.lookup_addr = 32'h302;
    #1 check("lookup_same_word", 32'(bus.lookup_hit), 32'd1);
    bus.lookup_addr = 32'h304;
    #1 check("lookup_other_word", 32'(bus.lookup_hit), 32'd0);
    bus.lookup_addr   = 32'h300;
    bus.mem_req_ready = 1'b1;
    #1 check("lookup_while_deq", 32'(bus.lookup_hit), 32'd1);
    @(posedge clk);
    #1 check("lookup_after_deq", 32'(bus.lookup_hit), 32'd0);
    bus.mem_req_ready = 1'b0;

    // Simultaneous enqueue/dequeue at count 2.
    enq_w(32'h500, 32'h5000_0000);
    enq_w(32'h504, 32'h5000_0001);
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      enq_w(32'h508 + 32'(4*i), 32'h5000_0002 + 32'(i));
      check("simul_count", 32'(count), 32'd2);
    end
    wait_drain();

    // Reset mid-drain.
    enq_w(32'h600, 32'h6000_0000);
    enq_w(32'h604, 32'h6000_0001);
    enq_w(32'h608, 32'h6000_0002);
    check("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.lookup_addr = 32'h600;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
    check("mid_rst_lookup", 32'(bus.lookup_hit), 32'd0);
    check("mid_rst_enq_ready", 32'(bus.enq_ready), 32'd1);
    enq_w(32'h700, 32'h7777_7777);
    wait_drain();

`ifdef WRITE_BUFFER_MERGE_EN
    enq(32'h400, 3'b000, 32'h0000_0011, 1'b1, 32'h400, 4'b0011, 32'h1111_2211);
    enq(32'h401, 3'b000, 32'h0000_0022, 1'b0, 32'h0, 4'b0000, 32'h0);
    check("merge_count", 32'(count), 32'd1);
    check("merge_be", 32'(bus.mem_be), 32'h3);
    check("merge_low_half", 32'(bus.mem_wdata[15:0]), 32'h2211);
    wait_drain();
`endif

    repeat (2) @(posedge clk);
    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/write_buffer.md
Name: write_buffer

Overview:
- Store buffer directly downstream of the write-through data cache, between the cache and data memory.
- Accepts every store the cache writes through and converts it to a lane-aligned, byte-enabled memory write. Queues up to DEPTH stores and drains them in order to memory over a valid/ready handshake.
- Gives the cache an address-conflict check, so a refill read never bypasses a pending store to the same word.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, data width; the block supports 32 only (4 byte lanes).
- DEPTH, 4, number of entries; must be a power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enq_valid  in  1  cache presents a store
- enq_ready  out  1  buffer can accept the store
- enq_addr  in  ADDR_WIDTH  store byte address
- enq_addr_mode  in  3  store width, using the DATA_ADDR_MODE_* defines (funct3: B=000, H=001, W=010, BU=100, HU=101)
- enq_data  in  DATA_WIDTH  store data, right-justified as it comes from the register file
- mem_req_valid  out  1  head entry is presented to memory
- mem_req_ready  in  1  memory accepts the write
- mem_addr  out  ADDR_WIDTH  word-aligned address; [1:0] are always 0
- mem_wdata  out  DATA_WIDTH  lane-aligned write data
- mem_be  out  4  byte enables
- lookup_addr  in  ADDR_WIDTH  cache refill address to check
- lookup_hit  out  1  a valid entry matches lookup_addr[ADDR_WIDTH-1:2]
- count  out  $clog2(DEPTH)+1  number of occupied entries
- empty  out  1  count == 0

Behaviour:
- Storage: circular array of entries {word_addr, wdata, be}, with head and tail pointers of $clog2(DEPTH) bits that wrap naturally, plus an occupancy counter.
- Reset: rst at a clock edge clears head, tail and count to 0 and invalidates all entries.
  - After reset: enq_ready=1, mem_req_valid=0, lookup_hit=0, empty=1, count=0.
  - Entry data fields need not be reset.
- Reset mid-operation: all queued stores are discarded, including a head being presented. mem_req_valid is 0 in the cycle after rst even if mem_req_ready was never seen.
- Alignment at enqueue:
  - B/BU: be = 1 << addr[1:0]; data byte replicated to all four lanes.
  - H/HU: be = addr[1] ? 4'b1100 : 4'b0011; halfword replicated to both halves. addr[0] is ignored; no misalignment trap.
  - W and any other code: be = 4'b1111, data unchanged.
  - Unsigned and signed variants align identically.
- Enqueue:
  - enq_ready = (count != DEPTH). There is no same-cycle full bypass.
  - A store is accepted at the clock edge when enq_valid && enq_ready. It is written at tail, and tail increments.
- Drain:
  - mem_req_valid = !empty. mem_addr, mem_wdata and mem_be come directly from the head entry's registers.
  - Outputs stay stable while mem_req_valid && !mem_req_ready.
  - On mem_req_valid && mem_req_ready, head increments at the edge. The next entry is presented the following cycle, so back-to-back drain runs at 1 store per cycle.
- Simultaneous enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
  - When count==DEPTH, enq_ready is still 0 that cycle even if a dequeue occurs.
  - When count==0, an enqueue is not visible on mem_req until the next cycle, giving a minimum latency of 1 cycle from accept to mem_req_valid.
- Lookup:
  - Combinational compare of lookup_addr[ADDR_WIDTH-1:2] against every occupied entry.
  - A store enqueued in the same cycle is not checked.
  - The head entry being dequeued this cycle still counts as a hit.
  - The cache must hold its refill while lookup_hit=1.
- Ordering: memory writes retire strictly in enqueue order unless merging (below) is enabled.

Optional Feature:
- Macro: WRITE_BUFFER_MERGE_EN.
- Defined: an enqueue whose word address equals the youngest occupied entry merges into that entry instead of allocating a new one.
  - Merge is allowed only if that entry is not the head being dequeued this cycle.
  - Merge rule: be |= new_be; new lanes overwrite old lanes; count and tail are unchanged.
  - A merge is accepted even when count==DEPTH; enq_ready then also covers this case.
- Undefined: no merging; every accepted store allocates an entry.

Decomposition:
- Shared package wb_pkg:
  - wb_entry_t packed struct {word_addr[ADDR_WIDTH-3:0], wdata[31:0], be[3:0]}.
  - Localparam NUM_LANES=4.
  - The block reuses the existing DATA_ADDR_MODE_* defines rather than redefining them.
- One natural sub-module: store_lane_align, purely combinational (addr[1:0], addr_mode, data) -> (be, lane_data). It is reusable by the cache's own byte-write path.

Test Plan:
- Reset and fill: after reset, hold mem_req_ready=0 and enqueue 4 words to 0x100, 0x104, 0x108, 0x10C.
  - Expect count=4, enq_ready=0, mem_req_valid=1, mem_addr=0x100, mem_be=4'b1111.
- Ordered drain: from the fill state, set mem_req_ready=1.
  - Expect addresses 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles; then empty=1 and mem_req_valid=0.
- Alignment:
  - sb 0xAB to 0x203 -> mem_addr=0x200, be=4'b1000, wdata[31:24]=0xAB.
  - sh 0x1234 to 0x206 -> be=4'b1100, wdata[31:16]=0x1234.
- Lookup: with a pending store at 0x300, set lookup_addr=0x302.
  - Expect lookup_hit=1; with lookup_addr=0x304, expect lookup_hit=0.
  - Expect lookup_hit to drop the cycle after the 0x300 write handshakes.
- Simultaneous enqueue/dequeue at count=2 with mem_req_ready=1 for 5 cycles:
  - count stays 2 and no store is lost or reordered.
- Reset mid-drain: assert rst while count=3 and mem_req_ready=0.
  - Next cycle: count=0, mem_req_valid=0.
  - With WRITE_BUFFER_MERGE_EN: sb 0x11 to 0x400 then sb 0x22 to 0x401 -> one entry, be=4'b0011, wdata[15:0]=0x2211.
